battleship_turn_ctrl: RTL and testbench

Turn sequencer for the Battleship game: owns the player's cursor, alternates shots between player and PC, and issues each shot to the board/hit-detect datapath over a valid/ready request with a pulsed response. It tracks remaining hull cells for both sides and declares the winner. It sits between the button front-end and the board memories. The seven-segment and message drivers consume its outputs.

---
 rtl/battleship_turn_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_battleship_turn_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/battleship_turn_ctrl.sv
// Purpose: Battleship turn sequencer: player cursor, player/PC shot alternation, hull tracking, winner.
// Latency: button rise -> cursor/request 1 cycle; hitValid -> state/count/gameState on the sampling edge.
// Backpressure: shotValid holds with stable fields until shotReady; hitValid outside a wait state is ignored.
//
// Ports:
//   clk, rstSwitch (async active-low)        clock / reset
//   rowButton, colButton, selectButton       debounced levels, edge-detected here
//   rowCoord, colCoord                       player cursor
//   turnPlayer                               1 = player's turn
//   shotValid/shotReady, shotPc, shotRow/Col shot request to the board datapath
//   hitValid, hit, already                   pulsed shot response
//   pcHullsLeft, playerHullsLeft             remaining ship cells per side
//   timeoutPulse                             one-cycle forfeit strobe
//   gameState                                00 playing, 01 player won, 10 PC won
module battleship_turn_ctrl #(
  parameter int GRID        = 5,
  parameter int HULLS       = 6,
  parameter int TURN_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rstSwitch,
  input  logic       rowButton,
  input  logic       colButton,
  input  logic       selectButton,
  output logic [2:0] rowCoord,
  output logic [2:0] colCoord,
  output logic       turnPlayer,
  output logic       shotValid,
  output logic       shotPc,
  output logic [2:0] shotRow,
  output logic [2:0] shotCol,
  input  logic       shotReady,
  input  logic       hitValid,
  input  logic       hit,
  input  logic       already,
  output logic [3:0] pcHullsLeft,
  output logic [3:0] playerHullsLeft,
  output logic       timeoutPulse,
  output logic [1:0] gameState
);

  localparam int          TW    = $clog2(TURN_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TURN_CYCLES - 1);
  localparam logic [2:0]  GMAX  = 3'(GRID - 1);
  localparam logic [3:0]  GLIM  = 4'(GRID);
  localparam logic [3:0]  HINIT = 4'(HULLS);

  typedef enum logic [2:0] {P_AIM, P_REQ, P_WAIT, PC_PICK, PC_REQ, PC_WAIT, DONE} state_t;

  state_t        r_state;
  logic          r_row_q, r_col_q, r_sel_q;
  logic [7:0]    r_lfsr;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_row, r_col, r_shot_row, r_shot_col;
  logic          r_turn, r_shot_vld, r_shot_pc, r_timeout;
  logic [3:0]    r_pc_hulls, r_pl_hulls;
  logic [1:0]    r_game;

  logic       w_row_rise, w_col_rise, w_sel_rise, w_any_rise;
  logic       w_lfsr_fb, w_cand_ok;
  logic [2:0] w_row_next, w_col_next;

  assign w_row_rise = rowButton & ~r_row_q;
  assign w_col_rise = colButton & ~r_col_q;
  assign w_sel_rise = selectButton & ~r_sel_q;
  assign w_any_rise = w_row_rise | w_col_rise | w_sel_rise;
  assign w_row_next = (r_row == GMAX) ? 3'd0 : r_row + 3'd1;
  assign w_col_next = (r_col == GMAX) ? 3'd0 : r_col + 3'd1;

  // Fibonacci taps 8,6,5,4 mapped onto bits [7],[5],[4],[3]
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  // 4-bit compare so GRID = 8 does not wrap to zero
  assign w_cand_ok = ({1'b0, r_lfsr[2:0]} < GLIM) && ({1'b0, r_lfsr[5:3]} < GLIM);

  always_ff @(posedge clk or negedge rstSwitch) begin
    if (!rstSwitch) begin
      r_state    <= P_AIM;
      r_row_q    <= 1'b0;
      r_col_q    <= 1'b0;
      r_sel_q    <= 1'b0;
      r_lfsr     <= 8'h01;
      r_timer    <= '0;
      r_row      <= 3'd0;
      r_col      <= 3'd0;
      r_shot_row <= 3'd0;
      r_shot_col <= 3'd0;
      r_turn     <= 1'b1;
      r_shot_vld <= 1'b0;
      r_shot_pc  <= 1'b0;
      r_timeout  <= 1'b0;
      r_pc_hulls <= HINIT;
      r_pl_hulls <= HINIT;
      r_game     <= 2'b00;
    end else begin
      r_row_q   <= rowButton;
      r_col_q   <= colButton;
      r_sel_q   <= selectButton;
      r_lfsr    <= {r_lfsr[6:0], w_lfsr_fb};
      r_timeout <= 1'b0;
      case (r_state)
        P_AIM: begin
          if (w_row_rise) r_row <= w_row_next;
          if (w_col_rise) r_col <= w_col_next;
          if (w_sel_rise) begin
            // select captures the cursor as it was before any same-cycle increment
            r_shot_row <= r_row;
            r_shot_col <= r_col;
            r_shot_pc  <= 1'b0;
            r_shot_vld <= 1'b1;
            r_timer    <= '0;
            r_state    <= P_REQ;
          end else if (w_any_rise) begin
            r_timer <= '0;
          end else if (r_timer == TLAST) begin
            r_timeout <= 1'b1;
            r_turn    <= 1'b0;
            r_timer   <= '0;
            r_state   <= PC_PICK;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        P_REQ: begin
          if (shotReady) begin
            r_shot_vld <= 1'b0;
            r_state    <= P_WAIT;
          end
        end
        PC_REQ: begin
          if (shotReady) begin
            r_shot_vld <= 1'b0;
            r_state    <= PC_WAIT;
          end
        end
        P_WAIT: begin
          if (hitValid) begin
            if (already) begin
              r_state <= P_AIM;
            end else if (hit && r_pc_hulls == 4'd1) begin
              r_pc_hulls <= 4'd0;
              r_game     <= 2'b01;
              r_state    <= DONE;
            end else begin
              if (hit && r_pc_hulls != 4'd0) r_pc_hulls <= r_pc_hulls - 4'd1;
              r_turn  <= 1'b0;
              r_state <= PC_PICK;
            end
          end
        end
        PC_PICK: begin
          if (w_cand_ok) begin
            r_shot_row <= r_lfsr[2:0];
            r_shot_col <= r_lfsr[5:3];
            r_shot_pc  <= 1'b1;
            r_shot_vld <= 1'b1;
            r_state    <= PC_REQ;
          end
        end
        PC_WAIT: begin
          if (hitValid) begin
            if (already) begin
              r_state <= PC_PICK;
            end else if (hit && r_pl_hulls == 4'd1) begin
              r_pl_hulls <= 4'd0;
              r_game     <= 2'b10;
              r_state    <= DONE;
            end else begin
              if (hit && r_pl_hulls != 4'd0) r_pl_hulls <= r_pl_hulls - 4'd1;
              r_turn  <= 1'b1;
              r_state <= P_AIM;
            end
          end
        end
        DONE: begin
          r_shot_vld <= 1'b0;
        end
        default: r_state <= P_AIM;
      endcase
    end
  end

  assign rowCoord        = r_row;
  assign colCoord        = r_col;
  assign turnPlayer      = r_turn;
  assign shotValid       = r_shot_vld;
  assign shotPc          = r_shot_pc;
  assign shotRow         = r_shot_row;
  assign shotCol         = r_shot_col;
  assign pcHullsLeft     = r_pc_hulls;
  assign playerHullsLeft = r_pl_hulls;
  assign timeoutPulse    = r_timeout;
  assign gameState       = r_game;

endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// Purpose: randomized self-checking bench for battleship_turn_ctrl with a game-level reference model.
// Latency: stimulus drives after the rising edge; outputs sampled on the falling edge.
// Backpressure: bench acts as the board datapath, stalling shotReady randomly.
module tb_battleship_turn_ctrl;
  localparam int GRID  = 5;
  localparam int HULLS = 6;
  localparam int TC    = 1000;

  logic       clk = 1'b0;
  logic       rstSwitch, rowButton, colButton, selectButton;
  logic       shotReady, hitValid, hit, already;
  logic [2:0] rowCoord, colCoord, shotRow, shotCol;
  logic       turnPlayer, shotValid, shotPc, timeoutPulse;
  logic [3:0] pcHullsLeft, playerHullsLeft;
  logic [1:0] gameState;

  always #5 clk = ~clk;

  battleship_turn_ctrl #(.GRID(GRID), .HULLS(HULLS), .TURN_CYCLES(TC)) dut (
    .clk(clk), .rstSwitch(rstSwitch),
    .rowButton(rowButton), .colButton(colButton), .selectButton(selectButton),
    .rowCoord(rowCoord), .colCoord(colCoord), .turnPlayer(turnPlayer),
    .shotValid(shotValid), .shotPc(shotPc), .shotRow(shotRow), .shotCol(shotCol),
    .shotReady(shotReady), .hitValid(hitValid), .hit(hit), .already(already),
    .pcHullsLeft(pcHullsLeft), .playerHullsLeft(playerHullsLeft),
    .timeoutPulse(timeoutPulse), .gameState(gameState)
  );

  typedef struct packed {
    logic       pc;
    logic [2:0] row;
    logic [2:0] col;
  } exp_t;

  exp_t expq[$];
  int total = 0;
  int bad = 0;
  int to_seen = 0;
  int to_exp = 0;

  // game-level model: cursor, hull counts, whose turn, result
  int m_row, m_col, m_pc_left, m_pl_left, m_turn, m_game;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // monitor: checks every accepted request against the scoreboard, and request stability
  initial begin
    exp_t prev;
    exp_t e;
    bit   prev_hold;
    prev_hold = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rstSwitch && shotValid) begin
        if (prev_hold) chk("req_stable", int'({shotPc, shotRow, shotCol}), int'(prev));
        if (shotReady) begin
          if (expq.size() == 0) begin
            chk("unexpected_req", expq.size(), 1);
          end else begin
            e = expq.pop_front();
            chk("req_pc", shotPc, e.pc);
            if (e.pc == 1'b0) begin
              chk("req_row", shotRow, e.row);
              chk("req_col", shotCol, e.col);
            end else begin
              chk("pc_row_range", int'(shotRow < GRID), 1);
              chk("pc_col_range", int'(shotCol < GRID), 1);
            end
          end
          prev_hold = 0;
        end else begin
          prev = {shotPc, shotRow, shotCol};
          prev_hold = 1;
        end
      end else begin
        prev_hold = 0;
      end
      if (rstSwitch && timeoutPulse) begin
        to_seen++;
        chk("timeout_turn", turnPlayer, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit r, input bit c, input bit s, input int hold);
    rowButton = r;
    colButton = c;
    selectButton = s;
    repeat (hold) step();
    rowButton = 0;
    colButton = 0;
    selectButton = 0;
    step();
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0; m_pc_left = HULLS; m_pl_left = HULLS; m_turn = 1; m_game = 0;
    expq.delete();
  endtask

  task automatic do_reset();
    rstSwitch = 0;
    rowButton = 0; colButton = 0; selectButton = 0;
    shotReady = 0; hitValid = 0; hit = 0; already = 0;
    model_reset();
    step();
    step();
    rstSwitch = 1;
    step();
  endtask

  // waits for a request, stalls it randomly, accepts it and checks that valid drops
  task automatic transfer(output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (shotValid) begin
        ok = 1;
        break;
      end
    end
    chk("req_seen", int'(ok), 1);
    if (!ok) return;
    step();
    repeat ($urandom_range(0, 5)) step();
    shotReady = 1;
    step();
    shotReady = 0;
    @(negedge clk);
    chk("valid_drop", shotValid, 0);
    step();
  endtask

  task automatic respond(input bit pc_side, input int hit_pct);
    int r;
    bit h, a;
    r = $urandom_range(0, 99);
    a = (r < 15);
    h = a ? 1'($urandom_range(0, 1)) : (r < 15 + hit_pct);
    repeat ($urandom_range(0, 2)) step();
    hitValid = 1; hit = h; already = a;
    step();
    hitValid = 0; hit = 0; already = 0;
    if (!a) begin
      if (!pc_side) begin
        if (h) m_pc_left--;
        if (m_pc_left == 0) m_game = 1; else m_turn = 0;
      end else begin
        if (h) m_pl_left--;
        if (m_pl_left == 0) m_game = 2; else m_turn = 1;
      end
    end
    @(negedge clk);
    chk("turn", turnPlayer, m_turn);
    chk("pc_hulls", pcHullsLeft, m_pc_left);
    chk("pl_hulls", playerHullsLeft, m_pl_left);
    chk("game", gameState, m_game);
    step();
  endtask

  task automatic player_turn(input int hit_pct, output bit ok);
    exp_t e;
    if ($urandom_range(0, 3) == 0) begin
      // response strobe while aiming must be ignored
      hitValid = 1; hit = 1;
      step();
      hitValid = 0; hit = 0;
      @(negedge clk);
      chk("stray_hit_hulls", pcHullsLeft, m_pc_left);
      chk("stray_hit_turn", turnPlayer, 1);
      step();
    end
    repeat ($urandom_range(0, 6)) begin
      press(1, 0, 0, $urandom_range(1, 3));
      m_row = (m_row + 1) % GRID;
    end
    repeat ($urandom_range(0, 6)) begin
      press(0, 1, 0, $urandom_range(1, 3));
      m_col = (m_col + 1) % GRID;
    end
    chk("cursor_row", rowCoord, m_row);
    chk("cursor_col", colCoord, m_col);
    e.pc = 0;
    e.row = 3'(m_row);
    e.col = 3'(m_col);
    expq.push_back(e);
    if ($urandom_range(0, 2) == 0) begin
      bit cb;
      cb = 1'($urandom_range(0, 1));
      press(1, cb, 1, $urandom_range(1, 3));
      m_row = (m_row + 1) % GRID;
      if (cb) m_col = (m_col + 1) % GRID;
    end else begin
      press(0, 0, 1, $urandom_range(1, 3));
    end
    transfer(ok);
    if (!ok) return;
    chk("cursor_row_post", rowCoord, m_row);
    chk("cursor_col_post", colCoord, m_col);
    respond(0, hit_pct);
  endtask

  task automatic pc_turn(input int hit_pct, output bit ok);
    exp_t e;
    e = '0;
    e.pc = 1;
    expq.push_back(e);
    transfer(ok);
    if (!ok) return;
    respond(1, hit_pct);
  endtask

  task automatic play_game(input int p_hit, input int pc_hit);
    bit ok;
    int seen;
    do_reset();
    for (int t = 0; t < 300 && m_game == 0; t++) begin
      if (m_turn == 1) player_turn(p_hit, ok);
      else pc_turn(pc_hit, ok);
      if (!ok) break;
    end
    chk("game_over", int'(m_game != 0), 1);
    // DONE is sticky: no requests, no cursor motion
    press(0, 0, 1, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (shotValid) seen++;
    end
    chk("done_no_req", seen, 0);
    step();
    press(1, 1, 0, 2);
    chk("done_row", rowCoord, m_row);
    chk("done_game", gameState, m_game);
    chk("done_pc_hulls", pcHullsLeft, m_pc_left);
  endtask

  initial begin
    int cnt;
    bit ok;
    do_reset();
    @(negedge clk);
    chk("rst_row", rowCoord, 0);
    chk("rst_col", colCoord, 0);
    chk("rst_turn", turnPlayer, 1);
    chk("rst_valid", shotValid, 0);
    chk("rst_pc", shotPc, 0);
    chk("rst_shot_row", shotRow, 0);
    chk("rst_shot_col", shotCol, 0);
    chk("rst_pc_hulls", pcHullsLeft, HULLS);
    chk("rst_pl_hulls", playerHullsLeft, HULLS);
    chk("rst_timeout", timeoutPulse, 0);
    chk("rst_game", gameState, 0);
    step();

    // held presses count once: expect 1,2,3,4,0,1
    for (int i = 0; i < 6; i++) begin
      press(1, 0, 0, 2);
      m_row = (m_row + 1) % GRID;
      chk("row_step", rowCoord, m_row);
    end

    play_game(85, 0);
    play_game(45, 45);
    play_game(10, 80);

    // idle forfeit measured from reset release
    rstSwitch = 0;
    model_reset();
    step();
    rstSwitch = 1;
    cnt = 0;
    for (int i = 0; i < TC + 20; i++) begin
      @(negedge clk);
      cnt++;
      if (timeoutPulse) break;
    end
    to_exp++;
    chk("timeout_cycles", cnt, TC + 1);
    @(negedge clk);
    chk("timeout_width", timeoutPulse, 0);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (shotValid) begin
        ok = 1;
        break;
      end
    end
    chk("pc_req_after_timeout", int'(ok), 1);
    chk("pc_req_shooter", shotPc, 1);
    #2;
    rstSwitch = 0;
    #1;
    chk("arst_valid", shotValid, 0);
    chk("arst_pc", shotPc, 0);
    chk("arst_turn", turnPlayer, 1);
    chk("arst_game", gameState, 0);
    chk("arst_hulls", pcHullsLeft, HULLS);
    step();
    rstSwitch = 1;
    repeat (3) step();
    chk("timeout_count", to_seen, to_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
